// File: rtl/alu_pkg.sv
// Shared definitions for the alu_exec execution unit: opcodes, shift sub-codes,
// flag bit positions, iteration counts and the sequencer state encoding.
package alu_pkg;

    localparam int WIDTH = 16;

    localparam logic [4:0] OP_ADD     = 5'd0;
    localparam logic [4:0] OP_SUB     = 5'd1;
    localparam logic [4:0] OP_MUL     = 5'd2;
    localparam logic [4:0] OP_DIV     = 5'd3;
    localparam logic [4:0] OP_MOD     = 5'd4;
    localparam logic [4:0] OP_AND     = 5'd5;
    localparam logic [4:0] OP_OR      = 5'd6;
    localparam logic [4:0] OP_XOR     = 5'd7;
    localparam logic [4:0] OP_NOT     = 5'd8;
    localparam logic [4:0] OP_NEG     = 5'd9;
    localparam logic [4:0] OP_INC     = 5'd10;
    localparam logic [4:0] OP_DEC     = 5'd11;
    localparam logic [4:0] OP_SHORT_B = 5'd12;
    localparam logic [4:0] OP_RAD     = 5'd13;
    localparam logic [4:0] OP_POW     = 5'd14;

    // opsel = 1_t_ooo selects the shift group
    localparam int         SHIFT_MSB = 4;
    localparam logic [2:0] SH_LSL    = 3'd0;
    localparam logic [2:0] SH_LSR    = 3'd1;
    localparam logic [2:0] SH_ASR    = 3'd2;
    localparam logic [2:0] SH_ROL    = 3'd3;
    localparam logic [2:0] SH_ROR    = 3'd4;

    localparam int ZF = 3;
    localparam int NF = 2;
    localparam int CF = 1;
    localparam int OF = 0;

    localparam int DIV_ITER = 16;
    localparam int POW_ITER = 16;
    localparam int RAD_ITER = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    function automatic logic [3:0] make_flags(input logic [WIDTH-1:0] res,
                                              input logic c, input logic o);
        logic [3:0] f;
        f     = '0;
        f[ZF] = (res == '0);
        f[NF] = res[WIDTH-1];
        f[CF] = c;
        f[OF] = o;
        return f;
    endfunction

endpackage

// File: rtl/alu_exec_divider.sv
// alu_iter_divider: unsigned restoring divider, one quotient bit per clock,
// DIV_ITER steps after start. A zero divisor naturally yields all-ones / dividend.
module alu_iter_divider
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [4:0]       cnt_q;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             take;

    always_comb begin
        trial = {rem_q, dvd_q[WIDTH-1]};
        diff  = trial - {1'b0, dvs_q};
        take  = (trial >= {1'b0, dvs_q});
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dvd_q <= '0;
            dvs_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            dvd_q <= dividend;
            dvs_q <= divisor;
            quo_q <= '0;
            rem_q <= '0;
            cnt_q <= 5'(DIV_ITER);
        end else if (cnt_q != 5'd0) begin
            dvd_q <= dvd_q << 1;
            quo_q <= {quo_q[WIDTH-2:0], take};
            rem_q <= take ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
            cnt_q <= cnt_q - 5'd1;
        end
    end

    // High while the final step is being taken; results are valid the cycle after.
    assign done        = (cnt_q == 5'd1);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = (dvs_q == '0);

endmodule

// File: rtl/alu_exec.sv
// alu_exec: single-cycle logic/arith/MUL/shift plus iterative DIV/MOD (and POW/RAD
// when ALU_POW_RAD_EN is defined), sequenced by an IDLE/BUSY/DONE FSM.
module alu_exec
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [4:0]       opsel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             ready,
    output logic             busy
);

    // Handshake: the control unit presents valid+opsel+operands and holds them until
    // ready. In IDLE a single-cycle op returns ready=valid in the same cycle; an
    // iterative op is latched on the accepting edge, ready stays low through BUSY,
    // and the registered result is presented with ready=1 for exactly one DONE cycle.

    alu_state_e       state_q, state_d;
    logic [4:0]       op_q;
    logic [4:0]       cnt_q;
    logic [4:0]       iter_len;
    logic             iter_op;
    logic             accept;
    logic             expire;

    logic             div_start, div_done, div_dbz;
    logic [WIDTH-1:0] div_quo, div_rem;

    logic [WIDTH-1:0] comb_res;
    logic             comb_c, comb_o;
    logic [WIDTH-1:0] done_res;
    logic             done_c, done_o;

    logic [WIDTH-1:0] ax, ay;
    logic             asub;
    logic [WIDTH:0]   sum;
    logic [31:0]      prod;
    logic [WIDTH-1:0] amt;
    logic [31:0]      sh_tmp;

    always_comb begin
        iter_op = (opsel == OP_DIV) || (opsel == OP_MOD);
`ifdef ALU_POW_RAD_EN
        iter_op = iter_op || (opsel == OP_POW) || (opsel == OP_RAD);
`endif
        accept    = (state_q == ST_IDLE) && valid && iter_op;
        div_start = accept && ((opsel == OP_DIV) || (opsel == OP_MOD));
        iter_len  = (opsel == OP_RAD) ? 5'(RAD_ITER) : 5'(DIV_ITER);
        expire    = ((op_q == OP_DIV) || (op_q == OP_MOD)) ? div_done : (cnt_q == 5'd1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= opsel;
                cnt_q <= iter_len;
            end else if ((state_q == ST_BUSY) && (cnt_q != 5'd0)) begin
                cnt_q <= cnt_q - 5'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_BUSY;
            ST_BUSY: if (expire) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    alu_iter_divider u_div (
        .clk        (clk),
        .rst        (rst),
        .start      (div_start),
        .dividend   (a),
        .divisor    (b),
        .done       (div_done),
        .quotient   (div_quo),
        .remainder  (div_rem),
        .div_by_zero(div_dbz)
    );

`ifdef ALU_POW_RAD_EN
    logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [3:0]       bit_idx;
    logic [31:0]      sq, pm;
    logic [7:0]       rad_trial;
    logic [WIDTH-1:0] rad_sq;

    // POW walks B MSB-first (square, then multiply on a set bit); RAD builds the
    // root MSB-first, keeping a trial bit whenever its square still fits under A.
    always_comb begin
        bit_idx   = 4'(cnt_q - 5'd1);
        sq        = 32'(acc_q) * 32'(acc_q);
        pm        = 32'(sq[WIDTH-1:0]) * 32'(a_q);
        rad_trial = acc_q[7:0] | (8'd1 << bit_idx[2:0]);
        rad_sq    = 16'(rad_trial) * 16'(rad_trial);
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        if (op_q == OP_POW) begin
            acc_d = b_q[bit_idx] ? pm[WIDTH-1:0] : sq[WIDTH-1:0];
            ovf_d = ovf_q | (sq[31:16] != 16'd0) | (b_q[bit_idx] & (pm[31:16] != 16'd0));
        end else if (op_q == OP_RAD) begin
            if (rad_sq <= a_q) acc_d = {8'd0, rad_trial};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b;
            acc_q <= (opsel == OP_POW) ? 16'd1 : 16'd0;
            ovf_q <= 1'b0;
        end else if (state_q == ST_BUSY) begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end
`endif

    always_comb begin
        done_res = '0;
        done_c   = 1'b0;
        done_o   = 1'b0;
        case (op_q)
            OP_DIV: begin done_res = div_quo; done_o = div_dbz; end
            OP_MOD: begin done_res = div_rem; done_o = div_dbz; end
`ifdef ALU_POW_RAD_EN
            OP_POW: begin done_res = acc_q; done_c = ovf_q; done_o = ovf_q; end
            OP_RAD: done_res = acc_q;
`endif
            default: ;
        endcase
    end

    // Shared adder: NEG is 0-A, INC/DEC use a constant 1.
    always_comb begin
        ax   = a;
        ay   = b;
        asub = 1'b0;
        case (opsel)
            OP_SUB: asub = 1'b1;
            OP_INC: ay = 16'd1;
            OP_DEC: begin ay = 16'd1; asub = 1'b1; end
            OP_NEG: begin ax = '0; ay = a; asub = 1'b1; end
            default: ;
        endcase
        sum = asub ? ({1'b0, ax} - {1'b0, ay}) : ({1'b0, ax} + {1'b0, ay});
    end

    always_comb begin
        comb_res = a;
        comb_c   = 1'b0;
        comb_o   = 1'b0;
        sh_tmp   = '0;
        prod     = 32'(a) * 32'(b);
        amt      = opsel[3] ? {12'd0, b[3:0]} : b;
        if (opsel[SHIFT_MSB]) begin
            case (opsel[2:0])
                SH_LSL: begin
                    sh_tmp   = {16'd0, a} << amt;
                    comb_res = sh_tmp[15:0];
                    comb_c   = sh_tmp[16];
                end
                SH_LSR: begin
                    sh_tmp   = {a, 16'd0} >> amt;
                    comb_res = sh_tmp[31:16];
                    comb_c   = sh_tmp[15];
                end
                SH_ASR: begin
                    sh_tmp   = $signed({a, 16'd0}) >>> amt;
                    comb_res = sh_tmp[31:16];
                    comb_c   = sh_tmp[15];
                end
                SH_ROL: begin
                    sh_tmp   = {a, a} << amt[3:0];
                    comb_res = sh_tmp[31:16];
                    comb_c   = (amt != '0) & sh_tmp[16];
                end
                SH_ROR: begin
                    sh_tmp   = {a, a} >> amt[3:0];
                    comb_res = sh_tmp[15:0];
                    comb_c   = (amt != '0) & sh_tmp[15];
                end
                default: ;
            endcase
        end else begin
            case (opsel)
                OP_ADD, OP_INC: begin
                    comb_res = sum[WIDTH-1:0];
                    comb_c   = sum[WIDTH];
                    comb_o   = (ax[15] == ay[15]) && (sum[15] != ax[15]);
                end
                OP_SUB, OP_DEC, OP_NEG: begin
                    comb_res = sum[WIDTH-1:0];
                    comb_c   = sum[WIDTH];
                    comb_o   = (ax[15] != ay[15]) && (sum[15] != ax[15]);
                end
                OP_MUL: begin
                    comb_res = prod[15:0];
                    comb_c   = (prod[31:16] != 16'd0);
                    comb_o   = (prod[31:16] != 16'd0);
                end
                OP_DIV, OP_MOD: comb_res = '0;
                OP_AND:     comb_res = a & b;
                OP_OR:      comb_res = a | b;
                OP_XOR:     comb_res = a ^ b;
                OP_NOT:     comb_res = ~a;
                OP_SHORT_B: comb_res = b;
`ifdef ALU_POW_RAD_EN
                OP_RAD, OP_POW: comb_res = '0;
`else
                OP_RAD, OP_POW: begin
                    comb_res = '0;
                    comb_o   = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        result = '0;
        flags  = '0;
        ready  = 1'b0;
        busy   = 1'b0;
        if (rst) begin
            case (state_q)
                ST_IDLE: begin
                    result = comb_res;
                    flags  = make_flags(comb_res, comb_c, comb_o);
                    ready  = valid && !iter_op;
                end
                ST_BUSY: busy = 1'b1;
                ST_DONE: begin
                    result = done_res;
                    flags  = make_flags(done_res, done_c, done_o);
                    ready  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed test-plan cases, randomized ops and an
// asynchronous reset during a divide, all scored against a behavioural model.
module tb_alu_exec;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [4:0]  opsel;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] result;
    logic [3:0]  flags;
    logic        ready;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    logic        exp_rdy  = 1'b0;
    logic        exp_busy = 1'b0;
    logic [19:0] exp_q[$];

    alu_exec dut (
        .clk   (clk),
        .rst   (rst),
        .valid (valid),
        .opsel (opsel),
        .a     (a),
        .b     (b),
        .result(result),
        .flags (flags),
        .ready (ready),
        .busy  (busy)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic apply_reset(input int cycles);
        rst      = 1'b0;
        valid    = 1'b0;
        exp_rdy  = 1'b0;
        exp_busy = 1'b0;
        repeat (cycles) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit is_iter(input logic [4:0] op);
`ifdef ALU_POW_RAD_EN
        return (op == 5'd3) || (op == 5'd4) || (op == 5'd13) || (op == 5'd14);
`else
        return (op == 5'd3) || (op == 5'd4);
`endif
    endfunction

    // Behavioural model: returns {result, Z, N, C, O}.
    function automatic logic [19:0] model(input logic [4:0] op, input logic [15:0] av,
                                          input logic [15:0] bv);
        logic [15:0] r, v;
        logic        c, o;
        int          sa, sb, s, steps, amt;
        longint      p, acc;
        r  = av;
        c  = 1'b0;
        o  = 1'b0;
        sa = int'($signed(av));
        sb = int'($signed(bv));
        if (op[4]) begin
            amt = op[3] ? int'(bv[3:0]) : int'(bv);
            if (op[2:0] <= 3'd2)      steps = (amt > 32) ? 32 : amt;
            else if (op[2:0] <= 3'd4) steps = (amt == 0) ? 0 : ((amt - 1) % 16) + 1;
            else                      steps = 0;
            v = av;
            for (int i = 0; i < steps; i++) begin
                case (op[2:0])
                    3'd0:    begin c = v[15]; v = {v[14:0], 1'b0};  end
                    3'd1:    begin c = v[0];  v = {1'b0, v[15:1]};  end
                    3'd2:    begin c = v[0];  v = {v[15], v[15:1]}; end
                    3'd3:    begin c = v[15]; v = {v[14:0], v[15]}; end
                    default: begin c = v[0];  v = {v[0], v[15:1]};  end
                endcase
            end
            r = v;
        end else begin
            case (op)
                5'd0:  begin s = int'(av) + int'(bv); r = 16'(s); c = s > 65535;
                             o = (sa + sb > 32767) || (sa + sb < -32768); end
                5'd1:  begin s = int'(av) - int'(bv); r = 16'(s); c = av < bv;
                             o = (sa - sb > 32767) || (sa - sb < -32768); end
                5'd2:  begin p = longint'(av) * longint'(bv); r = p[15:0];
                             c = p >= 65536; o = c; end
                5'd3:  begin if (bv == 0) begin r = 16'hFFFF; o = 1'b1; end else r = av / bv; end
                5'd4:  begin if (bv == 0) begin r = av; o = 1'b1; end else r = av % bv; end
                5'd5:  r = av & bv;
                5'd6:  r = av | bv;
                5'd7:  r = av ^ bv;
                5'd8:  r = ~av;
                5'd9:  begin s = -int'(av); r = 16'(s); c = av != 0; o = (-sa > 32767); end
                5'd10: begin s = int'(av) + 1; r = 16'(s); c = s > 65535; o = (sa + 1 > 32767); end
                5'd11: begin s = int'(av) - 1; r = 16'(s); c = av < 1; o = (sa - 1 < -32768); end
                5'd12: r = bv;
`ifdef ALU_POW_RAD_EN
                5'd13: begin
                    s = 0;
                    while ((s + 1) * (s + 1) <= int'(av)) s++;
                    r = 16'(s);
                end
                5'd14: begin
                    acc = 1;
                    for (int i = 15; i >= 0; i--) begin
                        acc = acc * acc;
                        if (acc >= 65536) o = 1'b1;
                        acc = acc % 65536;
                        if (bv[i]) begin
                            acc = acc * longint'(av);
                            if (acc >= 65536) o = 1'b1;
                            acc = acc % 65536;
                        end
                    end
                    r = acc[15:0];
                    c = o;
                end
`else
                5'd13, 5'd14: begin r = 16'd0; o = 1'b1; end
`endif
                default: r = av;
            endcase
        end
        return {r, (r == 16'd0), r[15], c, o};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic junk_inputs();
        valid = 1'($urandom_range(0, 1));
        opsel = 5'($urandom_range(0, 31));
        a     = 16'($urandom);
        b     = 16'($urandom);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            junk_inputs();
            valid    = 1'b0;
            exp_rdy  = 1'b0;
            exp_busy = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_op(input logic [4:0] op, input logic [15:0] av, input logic [15:0] bv);
        logic [19:0] e;
        int          n;
        e     = model(op, av, bv);
        valid = 1'b1;
        opsel = op;
        a     = av;
        b     = bv;
        if (!is_iter(op)) begin
            exp_busy = 1'b0;
            exp_rdy  = 1'b1;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
        end else begin
            n        = (op == 5'd13) ? 8 : 16;
            exp_busy = 1'b0;
            exp_rdy  = 1'b0;
            @(posedge clk);
            #1;
            for (int i = 0; i < n; i++) begin
                junk_inputs();
                exp_busy = 1'b1;
                exp_rdy  = 1'b0;
                @(posedge clk);
                #1;
            end
            junk_inputs();
            exp_busy = 1'b0;
            exp_rdy  = 1'b1;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
        end
        valid    = 1'b0;
        exp_rdy  = 1'b0;
        exp_busy = 1'b0;
    endtask

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'h7FFF;
            2:       return 16'h8000;
            3:       return 16'hFFFF;
            4:       return 16'($urandom_range(0, 20));
            default: return 16'($urandom);
        endcase
    endfunction

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        logic [19:0] e;
        if (!rst) begin
            check("reset_outputs", {10'd0, result, flags, ready, busy}, 32'd0);
        end else begin
            check("ready", {31'd0, ready}, {31'd0, exp_rdy});
            check("busy", {31'd0, busy}, {31'd0, exp_busy});
            if (exp_rdy) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL result_queue at %0t: got empty want entry", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("result", {16'd0, result}, {16'd0, e[19:4]});
                    check("flags", {28'd0, flags}, {28'd0, e[3:0]});
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [4:0]  op;
        logic [15:0] av, bv;
        valid = 1'b0;
        opsel = '0;
        a     = '0;
        b     = '0;

        // Pin the model against hand-computed values.
        check("pin_add",   {12'd0, model(5'd0, 16'h7FFF, 16'd1)},  32'h80005);
        check("pin_div",   {12'd0, model(5'd3, 16'd100, 16'd7)},   32'h000E0);
        check("pin_mod",   {12'd0, model(5'd4, 16'd100, 16'd7)},   32'h00020);
        check("pin_div0",  {12'd0, model(5'd3, 16'd5, 16'd0)},     32'hFFFF5);
        check("pin_mod0",  {12'd0, model(5'd4, 16'd5, 16'd0)},     32'h00051);
        check("pin_asr_t", {12'd0, model(5'd26, 16'h8004, 16'd2)}, 32'hE0014);
        check("pin_asr_b", {12'd0, model(5'd18, 16'h8004, 16'd20)}, 32'hFFFF6);
        check("pin_neg",   {12'd0, model(5'd9, 16'h8000, 16'd0)},  32'h80007);
        check("pin_mul",   {12'd0, model(5'd2, 16'h0100, 16'h0100)}, 32'h0000B);
`ifdef ALU_POW_RAD_EN
        check("pin_pow",   {12'd0, model(5'd14, 16'd3, 16'd4)},    32'h00510);
        check("pin_pow_o", {12'd0, model(5'd14, 16'd2, 16'd16)},   32'h0000B);
        check("pin_rad",   {12'd0, model(5'd13, 16'd1000, 16'd0)}, 32'h001F0);
`else
        check("pin_pow",   {12'd0, model(5'd14, 16'd3, 16'd4)},    32'h00009);
`endif

        apply_reset(3);
        idle(2);

        // Directed cases
        do_op(5'd0, 16'h7FFF, 16'd1);
        do_op(5'd3, 16'd100, 16'd7);
        do_op(5'd4, 16'd100, 16'd7);
        do_op(5'd3, 16'd5, 16'd0);
        do_op(5'd4, 16'd5, 16'd0);
        do_op(5'd14, 16'd3, 16'd4);
        do_op(5'd14, 16'd2, 16'd16);
        do_op(5'd14, 16'd0, 16'd0);
        do_op(5'd13, 16'd1000, 16'd0);
        do_op(5'd13, 16'hFFFF, 16'd0);
        do_op(5'd26, 16'h8004, 16'd2);
        do_op(5'd18, 16'h8004, 16'd20);
        do_op(5'd16, 16'h8001, 16'd16);
        do_op(5'd17, 16'h8001, 16'd16);
        do_op(5'd19, 16'h8001, 16'd16);
        do_op(5'd20, 16'h8001, 16'd17);
        do_op(5'd9, 16'h8000, 16'd0);
        do_op(5'd15, 16'h1234, 16'd0);
        idle(1);

        // Randomized ops
        for (int k = 0; k < 250; k++) begin
            op = 5'($urandom_range(0, 31));
            av = pick_operand();
            bv = pick_operand();
            if (op[4] && !op[3] && ($urandom_range(0, 2) != 0)) bv = 16'($urandom_range(0, 40));
            if (((op == 5'd3) || (op == 5'd4)) && ($urandom_range(0, 7) == 0)) bv = 16'd0;
            if ((op == 5'd14) && ($urandom_range(0, 1) == 1)) bv = 16'($urandom_range(0, 20));
            if ($urandom_range(0, 3) == 0) idle(1 + $urandom_range(0, 2));
            do_op(op, av, bv);
        end

        // Asynchronous reset in the middle of a divide
        valid    = 1'b1;
        opsel    = 5'd3;
        a        = 16'd100;
        b        = 16'd7;
        exp_rdy  = 1'b0;
        exp_busy = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            junk_inputs();
            exp_busy = 1'b1;
            @(posedge clk);
            #1;
        end
        #2 rst = 1'b0;
        #1 check("reset_immediate", {10'd0, result, flags, ready, busy}, 32'd0);
        valid    = 1'b1;
        opsel    = 5'd0;
        exp_rdy  = 1'b0;
        exp_busy = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        valid = 1'b0;
        rst   = 1'b1;
        do_op(5'd0, 16'd2, 16'd3);
        do_op(5'd3, 16'd1000, 16'd10);
        idle(3);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execution unit on the responder side of the control unit's `opsel`/operand/`ready` interface.
- Takes `opsel` and the already-muxed A/B operands, and returns the result, `ready` and ZNCO flags.
- Logic, add/sub, MUL and shifts complete in the same cycle.
- DIV, MOD, POW and RAD run iteratively. `ready` stays low until the result is valid, which stalls PC and register writes through the control unit's `ready` gating.

Parameters:
- WIDTH, 16, datapath width. Only 16 is supported; the parameter exists for the package only.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- valid  in  1  an instruction is presented this cycle (from fetch)
- opsel  in  5  operation select, codes from alu_pkg
- a  in  16  operand A (already muxed)
- b  in  16  operand B (already muxed; immediate, or shift amount when used)
- result  out  16  ALU result
- flags  out  4  {ZF,NF,CF,OF} at bits 3..0
- ready  out  1  result/flags valid this cycle
- busy  out  1  iterative operation in progress

Behaviour:
- Opcodes:
  - 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 5 AND, 6 OR, 7 XOR, 8 NOT, 9 NEG, 10 INC, 11 DEC, 12 SHORT_B, 13 RAD, 14 POW.
  - Codes 15 and 16–31 not listed below are reserved: result=A, C=O=0.
- Shift encoding, opsel=1_t_ooo:
  - ooo: 0 LSL, 1 LSR, 2 ASR, 3 ROL, 4 ROR. ooo=5..7 reserved.
  - t=1: shift amount = b[3:0].
  - t=0: amount = b. An amount ≥16 gives 0 for LSL/LSR, sign fill for ASR, and mod 16 for rotates.
- Flags, all ops:
  - Z = (result==0), N = result[15].
  - ADD/INC: C = carry out, O = signed overflow.
  - SUB/DEC/NEG: C = borrow (A<B unsigned), O = signed overflow. NEG is computed as 0-A.
  - MUL: low 16 bits of A*B; C = O = (high half != 0).
  - Logic/NOT/SHORT_B/RAD: C = O = 0.
  - Shifts: C = last bit shifted out (0 if amount is 0), O = 0.
- Single-cycle ops: when the FSM is IDLE, `ready = valid` combinationally; `result`/`flags` are combinational.
- FSM states: IDLE, BUSY, DONE.
  - IDLE -> BUSY on the clock edge where `valid` is high and `opsel` ∈ {DIV, MOD, POW, RAD}. At that edge, A, B and opsel are latched and the iteration counter is loaded.
  - `ready` = 0 in the acceptance cycle and in every BUSY cycle.
  - BUSY lasts N cycles: N = 16 for DIV/MOD/POW, 8 for RAD. BUSY -> DONE when the counter expires.
  - DONE: `ready` = 1 for exactly one cycle. `result`/`flags` are driven from registers; `opsel`, `valid` and operands are ignored. DONE -> IDLE unconditionally.
  - Total latency: `ready` is high N+1 cycles after the acceptance cycle.
- DIV/MOD: unsigned restoring division, one quotient bit per cycle.
  - B == 0: DIV gives 16'hFFFF, MOD gives A; O = 1, C = 0.
- POW: A^B mod 2^16, square-and-multiply MSB-first over the 16 bits of B.
  - O = C = sticky overflow, set if any step's product high half is nonzero.
  - 0^0 = 1.
- RAD: floor(sqrt(A)) unsigned, one result bit per cycle.
- Input changes during BUSY have no effect; there is no abort.
- Reset, async and mid-operation: state = IDLE; counter, latched operands and result/flag registers = 0; `ready` = 0, `busy` = 0, `result` = 0, `flags` = 0 while `rst` is low.
- `busy` = 1 in BUSY only.

Optional Feature:
- Macro ALU_POW_RAD_EN.
- Defined: POW and RAD are iterative as described above.
- Undefined: no POW/RAD hardware is built. Both complete single-cycle with result = 0, Z = 1, N = 0, C = 0, O = 1 (O flags the missing op).

Decomposition:
- alu_pkg holds:
  - opsel codes (ADD..POW), shift sub-codes, and the shift-group MSB;
  - flag bit indices ZF = 3, NF = 2, CF = 1, OF = 0;
  - iteration counts DIV_ITER = 16, POW_ITER = 16, RAD_ITER = 8;
  - FSM state encoding.
- One sub-module, alu_iter_divider: a 16-cycle restoring divider with start/done, quotient and remainder, and a div-by-zero flag.
- POW, RAD and the combinational ops stay in alu_exec.

Test Plan:
- ADD a=16'h7FFF, b=1, valid=1 -> same cycle: ready=1, result=16'h8000, flags: N=1, O=1, C=0, Z=0.
- DIV a=100, b=7 -> ready low for 17 cycles, high on the 17th after acceptance, result=14 for one cycle. MOD with the same operands -> result=2.
- DIV a=5, b=0 -> result=16'hFFFF, O=1. MOD a=5, b=0 -> result=5, O=1.
- POW a=3, b=4 -> result=81, O=0. POW a=2, b=16 -> result=0, O=1, Z=1. RAD a=1000 -> result=31 after 9 cycles.
- Shift opsel={1,1,ASR}, a=16'h8004, b=2 -> result=16'hE001, C=0. Same with t=0, b=20 -> result=16'hFFFF, C=1.
- Deassert rst during BUSY of a DIV -> result=0, flags=0, ready=0, busy=0 immediately. After release, a new ADD completes in a single cycle.
